axis_echo_core: RTL

//  Parametrised receive-to-transmit echo engine between an RS232 receiver (AXI-stream out)
//  and an RS232 transmitter (AXI-stream in). Buffers words in a FIFO and applies a

---
 rtl/axis_echo_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axis_echo_core.sv
// Stream echo engine: FIFO-buffered rx->tx loopback with egress transform, echo counter and status LEDs.
// Define ECHO_STRETCH_EN to make the activity LEDs pulse-stretched instead of plain registered status.
module axis_echo_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int MODE           = 1,
  parameter int INCREMENT      = 1,
  parameter int COUNT_WIDTH    = 16,
  parameter int STRETCH_CYCLES = 13300000
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   overflow_i,
  input  logic [DATA_WIDTH-1:0]  idata_i,
  input  logic                   ivalid_i,
  output logic                   iready_o,
  output logic [DATA_WIDTH-1:0]  odata_o,
  output logic                   ovalid_o,
  input  logic                   oready_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic [7:0]             leds_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(INCREMENT);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_WIDTH < 1 || DATA_WIDTH > 16 ||
      STRETCH_CYCLES < 1) begin : g_bad_params
    $error("axis_echo_core: invalid parameter set");
  end

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            occ_q, occ_d;
  logic                   rst_done_q;
  logic                   sticky_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   led_ovf_q;
  logic                   led_in_q, led_eg_q;
  logic [4:0]             led_data_q;
  logic [4:0]             led_bits;
  logic [DATA_WIDTH-1:0]  head;
  logic                   accept, xfer;

  // rst_done_q keeps iready low for the whole reset and releases it on the first edge after
  assign iready_o = rst_done_q && (occ_q != FULL_OCC);
  assign ovalid_o = (occ_q != '0);
  assign accept   = ivalid_i && iready_o;
  assign xfer     = ovalid_o && oready_i;
  assign head     = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign leds_o   = {led_ovf_q, led_in_q, led_eg_q, led_data_q};

  always_comb begin
    odata_o = head;
    case (MODE)
      1:       odata_o = ~head;
      2:       odata_o = head + INC;
      default: odata_o = head;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, xfer})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_led_bits
    if (gi < DATA_WIDTH) begin : g_data
      assign led_bits[gi] = odata_o[gi];
    end else begin : g_zero
      assign led_bits[gi] = 1'b0;
    end
  end

  // Storage carries no reset: contents are discarded by clearing pointers and occupancy
  always_ff @(posedge clock_i) begin
    if (accept) mem_q[wr_ptr_q] <= idata_i;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rst_done_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      led_ovf_q  <= 1'b1;
      led_data_q <= 5'b01010;
    end else begin
      rst_done_q <= 1'b1;
      occ_q      <= occ_d;
      sticky_q   <= sticky_q | overflow_i;
      led_ovf_q  <= ~(sticky_q | overflow_i);
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (xfer) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        count_q    <= count_q + COUNT_WIDTH'(1);
        led_data_q <= ~led_bits;
      end
    end
  end

`ifdef ECHO_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);
  logic [SW-1:0] in_cnt_q, eg_cnt_q;

  // LED is lit for the reload edge plus RELOAD further cycles, i.e. STRETCH_CYCLES in total
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      in_cnt_q <= '0;
      eg_cnt_q <= '0;
      led_in_q <= 1'b0;
      led_eg_q <= 1'b1;
    end else begin
      if (accept) begin
        in_cnt_q <= RELOAD;
        led_in_q <= 1'b0;
      end else if (in_cnt_q != '0) begin
        in_cnt_q <= in_cnt_q - SW'(1);
        led_in_q <= 1'b0;
      end else begin
        led_in_q <= 1'b1;
      end
      if (xfer) begin
        eg_cnt_q <= RELOAD;
        led_eg_q <= 1'b0;
      end else if (eg_cnt_q != '0) begin
        eg_cnt_q <= eg_cnt_q - SW'(1);
        led_eg_q <= 1'b0;
      end else begin
        led_eg_q <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      led_in_q <= 1'b0;
      led_eg_q <= 1'b1;
    end else begin
      led_in_q <= ~ivalid_i;
      led_eg_q <= ~iready_o;
    end
  end
`endif
endmodule
